rasterizer_backend: RTL and testbench

RASTERIZER_BACKEND -- requirements
Module: rasterizer_backend

---
 rtl/rasterizer_backend.sv | 167 ++++++++++++++++
 tb/tb_rasterizer_backend.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rasterizer_backend.sv
// rtl/rasterizer_backend.sv - edge-function scan converter emitting covered pixels with barycentric weights
// Walks the bounding box row-major, one pixel per cycle, with a single-entry output register.
module rasterizer_backend #(
  parameter int DATAWIDTH    = 12,
  parameter int WEIGHT_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic signed [DATAWIDTH-1:0]     i_bb_tl [2],
  input  logic signed [DATAWIDTH-1:0]     i_bb_br [2],
  input  logic signed [2*DATAWIDTH-1:0]   i_edge_val0,
  input  logic signed [2*DATAWIDTH-1:0]   i_edge_val1,
  input  logic signed [2*DATAWIDTH-1:0]   i_edge_val2,
  input  logic signed [DATAWIDTH-1:0]     i_edge_delta0 [2],
  input  logic signed [DATAWIDTH-1:0]     i_edge_delta1 [2],
  input  logic signed [DATAWIDTH-1:0]     i_edge_delta2 [2],
  input  logic        [2*DATAWIDTH-1:0]   i_area_inv,
  input  logic                            i_dv,
  output logic                            o_next,
  output logic                            o_ready,
  output logic signed [DATAWIDTH-1:0]     o_x,
  output logic signed [DATAWIDTH-1:0]     o_y,
  output logic        [WEIGHT_WIDTH-1:0]  o_w0,
  output logic        [WEIGHT_WIDTH-1:0]  o_w1,
  output logic        [WEIGHT_WIDTH-1:0]  o_w2,
  output logic                            o_frag_dv,
  input  logic                            i_frag_ready,
  output logic                            o_tri_done
);
  localparam int EW = 2*DATAWIDTH;
  localparam int PW = 4*DATAWIDTH;
  localparam int SH = EW - WEIGHT_WIDTH;
  localparam logic signed [DATAWIDTH-1:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, INIT, SCAN, DRAIN} state_t;

  state_t                         state_q;
  logic signed [DATAWIDTH-1:0]    tl_x_q, tl_y_q, br_x_q, br_y_q, x_q, y_q;
  logic signed [DATAWIDTH-1:0]    dx_q [3];
  logic signed [DATAWIDTH-1:0]    dy_q [3];
  logic signed [EW-1:0]           val_q [3];
  logic signed [EW-1:0]           e_q [3];
  logic signed [EW-1:0]           row_q [3];
  logic        [EW-1:0]           area_inv_q;
  logic signed [DATAWIDTH-1:0]    x_out_q, y_out_q;
  logic        [WEIGHT_WIDTH-1:0] w_q [3];
  logic                           frag_dv_q;

  function automatic logic signed [EW-1:0] sx(input logic signed [DATAWIDTH-1:0] v);
    return {{DATAWIDTH{v[DATAWIDTH-1]}}, v};
  endfunction

  logic signed [EW-1:0]    e_init [3];
  logic signed [EW-1:0]    e_dx [3];
  logic signed [EW-1:0]    row_dy [3];
  logic        [PW-1:0]    prod [3];
  logic        [PW-1:0]    shr [3];
  logic [WEIGHT_WIDTH-1:0] w_d [3];
  logic                    covered, can_load, last_px, bb_empty;

  // Weights are only loaded for covered pixels, so E is non-negative and the product can be unsigned.
  always_comb begin
    covered = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e_init[i] = val_q[i] + sx(tl_x_q) * sx(dx_q[i]) + sx(tl_y_q) * sx(dy_q[i]);
      e_dx[i]   = e_q[i] + sx(dx_q[i]);
      row_dy[i] = row_q[i] + sx(dy_q[i]);
      prod[i]   = {{EW{1'b0}}, e_q[i]} * {{EW{1'b0}}, area_inv_q};
      shr[i]    = prod[i] >> SH;
      w_d[i]    = (|shr[i][PW-1:WEIGHT_WIDTH]) ? '1 : shr[i][WEIGHT_WIDTH-1:0];
      if (e_q[i][EW-1]) covered = 1'b0;
    end
  end

  assign can_load = !frag_dv_q || i_frag_ready;
  assign last_px  = (x_q == br_x_q) && (y_q == br_y_q);
  assign bb_empty = (tl_x_q > br_x_q) || (tl_y_q > br_y_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tl_x_q     <= '0;
      tl_y_q     <= '0;
      br_x_q     <= '0;
      br_y_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      area_inv_q <= '0;
      x_out_q    <= '0;
      y_out_q    <= '0;
      frag_dv_q  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        dx_q[i]  <= '0;
        dy_q[i]  <= '0;
        val_q[i] <= '0;
        e_q[i]   <= '0;
        row_q[i] <= '0;
        w_q[i]   <= '0;
      end
    end else begin
      if (frag_dv_q && i_frag_ready) frag_dv_q <= 1'b0;
      case (state_q)
        IDLE: if (i_dv) begin
          tl_x_q     <= i_bb_tl[0];
          tl_y_q     <= i_bb_tl[1];
          br_x_q     <= i_bb_br[0];
          br_y_q     <= i_bb_br[1];
          val_q[0]   <= i_edge_val0;
          val_q[1]   <= i_edge_val1;
          val_q[2]   <= i_edge_val2;
          dx_q[0]    <= i_edge_delta0[0];
          dy_q[0]    <= i_edge_delta0[1];
          dx_q[1]    <= i_edge_delta1[0];
          dy_q[1]    <= i_edge_delta1[1];
          dx_q[2]    <= i_edge_delta2[0];
          dy_q[2]    <= i_edge_delta2[1];
          area_inv_q <= i_area_inv;
          state_q    <= INIT;
        end
        INIT: begin
          for (int i = 0; i < 3; i++) begin
            e_q[i]   <= e_init[i];
            row_q[i] <= e_init[i];
          end
          x_q     <= tl_x_q;
          y_q     <= tl_y_q;
          state_q <= bb_empty ? DRAIN : SCAN;
        end
        // A covered pixel waits for the output register; uncovered pixels never stall.
        SCAN: if (!covered || can_load) begin
          if (covered) begin
            x_out_q   <= x_q;
            y_out_q   <= y_q;
            for (int i = 0; i < 3; i++) w_q[i] <= w_d[i];
            frag_dv_q <= 1'b1;
          end
          if (last_px) begin
            state_q <= DRAIN;
          end else if (x_q < br_x_q) begin
            x_q <= x_q + ONE;
            for (int i = 0; i < 3; i++) e_q[i] <= e_dx[i];
          end else begin
            for (int i = 0; i < 3; i++) begin
              row_q[i] <= row_dy[i];
              e_q[i]   <= row_dy[i];
            end
            x_q <= tl_x_q;
            y_q <= y_q + ONE;
          end
        end
        DRAIN: if (can_load) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_next     = (state_q == IDLE) && i_dv;
  assign o_ready    = (state_q == IDLE);
  assign o_tri_done = (state_q == DRAIN) && can_load;
  assign o_frag_dv  = frag_dv_q;
  assign o_x        = x_out_q;
  assign o_y        = y_out_q;
  assign o_w0       = w_q[0];
  assign o_w1       = w_q[1];
  assign o_w2       = w_q[2];

endmodule

// File: tb/tb_rasterizer_backend.sv
// tb/tb_rasterizer_backend.sv - scoreboard bench for rasterizer_backend with a per-pixel reference model
`timescale 1ns/1ps
module tb_rasterizer_backend;
  localparam int DW = 12;
  localparam int WW = 16;

  typedef struct packed {
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [WW-1:0] w0;
    logic [WW-1:0] w1;
    logic [WW-1:0] w2;
  } frag_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [DW-1:0]   bb_tl [2];
  logic signed [DW-1:0]   bb_br [2];
  logic signed [2*DW-1:0] ev0, ev1, ev2;
  logic signed [DW-1:0]   d0 [2];
  logic signed [DW-1:0]   d1 [2];
  logic signed [DW-1:0]   d2 [2];
  logic [2*DW-1:0]        area_inv;
  logic                   i_dv = 1'b0;
  logic                   o_next, o_ready, o_frag_dv, o_tri_done;
  logic                   i_frag_ready;
  logic signed [DW-1:0]   o_x, o_y;
  logic [WW-1:0]          o_w0, o_w1, o_w2;

  always #5 clk = ~clk;

  rasterizer_backend #(.DATAWIDTH(DW), .WEIGHT_WIDTH(WW)) dut (
    .clk(clk), .rst(rst),
    .i_bb_tl(bb_tl), .i_bb_br(bb_br),
    .i_edge_val0(ev0), .i_edge_val1(ev1), .i_edge_val2(ev2),
    .i_edge_delta0(d0), .i_edge_delta1(d1), .i_edge_delta2(d2),
    .i_area_inv(area_inv), .i_dv(i_dv),
    .o_next(o_next), .o_ready(o_ready),
    .o_x(o_x), .o_y(o_y), .o_w0(o_w0), .o_w1(o_w1), .o_w2(o_w2),
    .o_frag_dv(o_frag_dv), .i_frag_ready(i_frag_ready), .o_tri_done(o_tri_done)
  );

  int total = 0;
  int bad = 0;
  frag_t sb[$];
  int cyc = 0, frag_cnt = 0, done_cnt = 0, next_cnt = 0, stall20 = 0;
  int rdy_mode = 0;
  bit stalled = 0;
  bit prev_stall = 0;
  frag_t cur, held;

  int t_tlx, t_tly, t_brx, t_bry;
  int t_val [3];
  int t_dx [3];
  int t_dy [3];
  longint t_area;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference: visit every pixel of the box and keep those with all three wrapped edge values >= 0.
  task automatic push_model(output int n);
    longint el, p;
    logic signed [2*DW-1:0] e [3];
    bit cov;
    frag_t f;
    n = 0;
    for (int y = t_tly; y <= t_bry; y++) begin
      for (int x = t_tlx; x <= t_brx; x++) begin
        cov = 1;
        for (int i = 0; i < 3; i++) begin
          el = longint'(t_val[i]) + longint'(x) * longint'(t_dx[i]) + longint'(y) * longint'(t_dy[i]);
          e[i] = el[2*DW-1:0];
          if (e[i] < 0) cov = 0;
        end
        if (cov) begin
          f.x = DW'(x);
          f.y = DW'(y);
          p = (longint'(e[0]) * t_area) >>> 8;  f.w0 = (p > 65535) ? 16'hFFFF : WW'(p);
          p = (longint'(e[1]) * t_area) >>> 8;  f.w1 = (p > 65535) ? 16'hFFFF : WW'(p);
          p = (longint'(e[2]) * t_area) >>> 8;  f.w2 = (p > 65535) ? 16'hFFFF : WW'(p);
          sb.push_back(f);
          n++;
        end
      end
    end
  endtask

  task automatic set_tri(input int tlx, tly, brx, bry, v0, v1, v2,
                         dx0, dy0, dx1, dy1, dx2, dy2, input longint ar);
    t_tlx = tlx; t_tly = tly; t_brx = brx; t_bry = bry;
    t_val[0] = v0; t_val[1] = v1; t_val[2] = v2;
    t_dx[0] = dx0; t_dy[0] = dy0; t_dx[1] = dx1; t_dy[1] = dy1; t_dx[2] = dx2; t_dy[2] = dy2;
    t_area = ar;
  endtask

  task automatic apply_tri();
    bb_tl[0] = DW'(t_tlx); bb_tl[1] = DW'(t_tly);
    bb_br[0] = DW'(t_brx); bb_br[1] = DW'(t_bry);
    ev0 = (2*DW)'(t_val[0]); ev1 = (2*DW)'(t_val[1]); ev2 = (2*DW)'(t_val[2]);
    d0[0] = DW'(t_dx[0]); d0[1] = DW'(t_dy[0]);
    d1[0] = DW'(t_dx[1]); d1[1] = DW'(t_dy[1]);
    d2[0] = DW'(t_dx[2]); d2[1] = DW'(t_dy[2]);
    area_inv = (2*DW)'(t_area);
  endtask

  task automatic wait_next(output bit ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_next) begin ok = 1; break; end
    end
    if (!ok) fail_now("wait_next");
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (o_tri_done) begin ok = 1; break; end
    end
    if (!ok) fail_now("wait_done");
  endtask

  task automatic run_tri(output int span, output int nexp);
    bit ok;
    int t0;
    span = -1;
    nexp = 0;
    @(posedge clk); #1;
    apply_tri();
    i_dv = 1'b1;
    wait_next(ok);
    if (ok) begin
      t0 = cyc;
      push_model(nexp);
      @(posedge clk); #1;
      i_dv = 1'b0;
      wait_done(ok);
      if (ok) span = cyc - t0;
    end
    i_dv = 1'b0;
    @(posedge clk); #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: checks every transfer against the scoreboard and that stalled outputs hold.
  initial forever begin
    @(negedge clk);
    cur = {o_x, o_y, o_w0, o_w1, o_w2};
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (o_frag_dv && prev_stall) check("stall_hold", cur, held);
      if (o_frag_dv && i_frag_ready) begin
        if (sb.size() == 0) check("unexpected_frag", cur, 96'h0 - 96'h1);
        else check("frag", cur, sb.pop_front());
        frag_cnt++;
      end
      if (o_frag_dv && !i_frag_ready && o_x == 2 && o_y == 0) stall20++;
      prev_stall = o_frag_dv && !i_frag_ready;
      held = cur;
      if (o_tri_done) done_cnt++;
      if (o_next) begin
        next_cnt++;
        check("next_only_idle", o_ready, 1);
      end
    end
  end

  initial begin
    i_frag_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 1) begin
        i_frag_ready = ($urandom_range(0, 3) != 0);
      end else if (rdy_mode == 2 && !stalled && o_frag_dv && o_x == 2 && o_y == 0) begin
        i_frag_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        i_frag_ready = 1'b1;
        stalled = 1;
      end else begin
        i_frag_ready = 1'b1;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int span, nexp, f0, d0c, n0, sum;
    bit ok;
    set_tri(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_tri();
    repeat (3) @(negedge clk);
    check("rst_ready", o_ready, 1);
    check("rst_frag_dv", o_frag_dv, 0);
    check("rst_done", o_tri_done, 0);
    check("rst_next", o_next, 0);
    check("rst_xy", {o_x, o_y}, 0);
    check("rst_w", {o_w0, o_w1, o_w2}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reference triangle, ready held high.
    set_tri(0, 0, 4, 4, 0, 16, 0, 4, 0, -4, -4, 0, 4, 64'h100000);
    f0 = frag_cnt; d0c = done_cnt;
    run_tri(span, nexp);
    check("t19_span", span, 27);
    check("t19_frags", frag_cnt - f0, 15);
    check("t19_done", done_cnt - d0c, 1);
    check("t19_sb_empty", sb.size(), 0);

    // Same triangle with a 5-cycle stall on fragment (2,0).
    rdy_mode = 2; stalled = 0; stall20 = 0;
    f0 = frag_cnt;
    run_tri(span, nexp);
    check("t20_frags", frag_cnt - f0, 15);
    check("t20_stall_cycles", stall20, 5);
    check("t20_sb_empty", sb.size(), 0);
    rdy_mode = 0;

    // Inverted box.
    set_tri(5, 5, 4, 4, 1, 1, 1, 0, 0, 0, 0, 0, 0, 64'h100);
    f0 = frag_cnt;
    run_tri(span, nexp);
    check("t21_span", span, 2);
    check("t21_frags", frag_cnt - f0, 0);

    // All edges negative: 9 scan cycles, nothing emitted.
    set_tri(0, 0, 2, 2, -5, -1, -100, 0, 0, 0, 0, 0, 0, 64'h100);
    f0 = frag_cnt; d0c = done_cnt;
    run_tri(span, nexp);
    check("t22_span", span, 11);
    check("t22_frags", frag_cnt - f0, 0);
    check("t22_done", done_cnt - d0c, 1);

    // Reset in the middle of a scan with a fragment pending.
    set_tri(0, 0, 4, 4, 0, 16, 0, 4, 0, -4, -4, 0, 4, 64'h100000);
    @(posedge clk); #1;
    apply_tri();
    i_dv = 1'b1;
    wait_next(ok);
    push_model(nexp);
    @(posedge clk); #1;
    i_dv = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_frag_dv) begin ok = 1; break; end
    end
    if (!ok) fail_now("t23_frag_dv");
    d0c = done_cnt;
    #2 rst = 1'b1;
    #1;
    check("t23_frag_dv_cleared", o_frag_dv, 0);
    check("t23_ready", o_ready, 1);
    check("t23_no_done", o_tri_done, 0);
    sb.delete();
    @(posedge clk); #3;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("t23_no_done_after", done_cnt - d0c, 0);
    check("t23_idle_after", {o_ready, o_frag_dv}, 2'b10);

    // i_dv held high through two back-to-back triangles.
    n0 = next_cnt; d0c = done_cnt; f0 = frag_cnt;
    @(posedge clk); #1;
    set_tri(0, 0, 4, 4, 0, 16, 0, 4, 0, -4, -4, 0, 4, 64'h100000);
    apply_tri();
    i_dv = 1'b1;
    wait_next(ok);
    push_model(nexp);
    @(posedge clk); #1;
    set_tri(0, 0, 2, 2, 100, 200, 300, 0, 0, 0, 0, 0, 0, 64'h200);
    apply_tri();
    wait_done(ok);
    wait_next(ok);
    push_model(nexp);
    @(posedge clk); #1;
    i_dv = 1'b0;
    wait_done(ok);
    @(posedge clk); #1;
    check("t24_next_pulses", next_cnt - n0, 2);
    check("t24_done_pulses", done_cnt - d0c, 2);
    check("t24_frags", frag_cnt - f0, 24);
    check("t24_sb_empty", sb.size(), 0);

    // Randomized triangles with random backpressure.
    rdy_mode = 1;
    f0 = frag_cnt; d0c = done_cnt; sum = 0;
    for (int k = 0; k < 25; k++) begin
      int tlx, tly;
      tlx = int'($urandom_range(0, 8)) - 4;
      tly = int'($urandom_range(0, 8)) - 4;
      set_tri(tlx, tly, tlx + int'($urandom_range(0, 6)) - 1, tly + int'($urandom_range(0, 6)) - 1,
              int'($urandom_range(0, 80)) - 40, int'($urandom_range(0, 80)) - 40, int'($urandom_range(0, 80)) - 40,
              int'($urandom_range(0, 12)) - 6, int'($urandom_range(0, 12)) - 6,
              int'($urandom_range(0, 12)) - 6, int'($urandom_range(0, 12)) - 6,
              int'($urandom_range(0, 12)) - 6, int'($urandom_range(0, 12)) - 6,
              ($urandom_range(0, 1) != 0) ? longint'($urandom & 32'hFFFFFF) : longint'($urandom_range(0, 70000)));
      run_tri(span, nexp);
      sum += nexp;
    end
    rdy_mode = 0;
    repeat (4) @(posedge clk);
    #1;
    check("rand_frags", frag_cnt - f0, sum);
    check("rand_done", done_cnt - d0c, 25);
    check("rand_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
